hog_job_sequencer: RTL

HOG_JOB_SEQUENCER -- requirements
Module: hog_job_sequencer

---
 rtl/hog_job_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/hog_job_sequencer.sv
// hog_job_sequencer: host job FSM that sequences pixel load, image scaling and HOG feature extraction
module hog_job_sequencer #(
  parameter int IMAGE_SIZE = 18495,
  parameter int TO_W = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        cmd_ack,
  input  logic        load_wr,
  input  logic        scaling_finish,
  input  logic        write_feature_done,
  input  logic        histogram_done,
  output logic        scale_start,
  output logic        host_wr_allow,
  output logic        host_rd_allow,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  state,
  output logic        hist_seen,
  output logic [14:0] pix_cnt,
  output logic [31:0] cycle_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SCALE = 3'd2;
  localparam logic [2:0] S_HOG = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR = 3'd5;
  localparam logic [14:0] LAST = 15'(IMAGE_SIZE);
  localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - TO_W'(1);
  logic [2:0] nx, nrm;
  logic [1:0] nx_code;
  logic [TO_W-1:0] wd;
  logic active, jobbing, accept, entry;
  always_comb begin
    active = (state == S_SCALE) || (state == S_HOG);
    jobbing = active || (state == S_LOAD);
    accept = (state == S_IDLE) && cmd_start;
    case (state)
      S_IDLE:  nrm = cmd_start ? S_LOAD : S_IDLE;
      S_LOAD:  nrm = (load_wr && pix_cnt == LAST) ? S_SCALE : S_LOAD;
      S_SCALE: nrm = scaling_finish ? (write_feature_done ? S_DONE : S_HOG) : S_SCALE;
      S_HOG:   nrm = write_feature_done ? S_DONE : S_HOG;
      S_DONE:  nrm = cmd_ack ? S_IDLE : S_DONE;
      S_ERR:   nrm = cmd_ack ? S_IDLE : S_ERR;
      default: nrm = S_IDLE;
    endcase
    nx = nrm;
    nx_code = accept ? 2'b00 : err_code;
    if (cmd_abort && jobbing) begin
      nx = S_ERR;
      nx_code = 2'b11;
    end else if (active && wd == WD_LAST && nrm == state) begin
      nx = S_ERR;
      nx_code = (state == S_SCALE) ? 2'b01 : 2'b10;
    end
    entry = (nx != state) && (nx == S_SCALE || nx == S_HOG);
  end
  always_ff @(posedge aclk) begin
    if (rst) begin
      state <= S_IDLE;
      err_code <= 2'b00;
      scale_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      host_wr_allow <= 1'b0;
      host_rd_allow <= 1'b1;
      hist_seen <= 1'b0;
      pix_cnt <= '0;
      cycle_cnt <= '0;
      wd <= '0;
    end else begin
      state <= nx;
      err_code <= nx_code;
      scale_start <= (nx == S_SCALE) && (state != S_SCALE);
      busy <= (nx == S_LOAD) || (nx == S_SCALE) || (nx == S_HOG);
      done <= nx == S_DONE;
      err <= nx == S_ERR;
      host_wr_allow <= nx == S_LOAD;
      host_rd_allow <= (nx == S_IDLE) || (nx == S_DONE);
      if (accept) begin
        pix_cnt <= '0;
        cycle_cnt <= '0;
        hist_seen <= 1'b0;
        wd <= '0;
      end else begin
        if (state == S_LOAD && load_wr && pix_cnt != '1) pix_cnt <= pix_cnt + 15'd1;
        if (active && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
        if (active && histogram_done) hist_seen <= 1'b1;
        wd <= entry ? '0 : active ? wd + TO_W'(1) : wd;
      end
    end
  end
endmodule
